// File: rtl/ntt_sched.sv
// ntt_sched: issue/retire sequencer feeding one butterfly PE through full 256-point NTT/INTT passes.
// Build macro SCHED_FINAL_SCALE_EN appends an INTT scaling layer (PE_MODE_MUL, scale_o).
package ntt_sched_pkg;
   typedef enum logic [1:0] {
      PE_MODE_NTT  = 2'd0,
      PE_MODE_INTT = 2'd1,
      PE_MODE_MUL  = 2'd2
   } pe_mode_e;
endpackage

module ntt_sched
   import ntt_sched_pkg::*;
#(
   parameter int MEM_LAT  = 1,
   parameter int PIPE_LAT = 4,
   parameter int ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              inv_i,
   input  logic              hold_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_a_o,
   output logic [ADDR_W-1:0] rd_addr_b_o,
   output logic [6:0]        tw_idx_o,
   output pe_mode_e          pe_ctrl_o,
   output logic              pe_valid_o,
   input  logic              pe_valid_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_a_o,
   output logic [ADDR_W-1:0] wr_addr_b_o,
   output logic              scale_o
);
   localparam int DLY   = MEM_LAT + PIPE_LAT;
   localparam int CNT_W = $clog2(DLY + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;
   typedef struct packed {
      logic              vld;
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
   } ret_t;
   typedef struct packed {
      logic       vld;
      logic [6:0] tw;
      pe_mode_e   mode;
      logic       scale;
   } iss_t;

   state_e           state_q, state_d;
   logic [2:0]       layer_q, layer_d;
   logic [6:0]       bfly_q, bfly_d, k_q, k_d;
   logic             inv_q, inv_d, err_q;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   ret_t             ret_q [DLY];
   iss_t             iss_q [MEM_LAT];

   logic              issue, retire, scale_layer, grp_end;
   logic [2:0]        shift, last_layer;
   logic [ADDR_W-1:0] bfly_x, len_v, mask_v, addr_a, addr_b;
   pe_mode_e          mode;

`ifdef SCHED_FINAL_SCALE_EN
   assign scale_layer = (layer_q == 3'd7);
   assign last_layer  = inv_q ? 3'd7 : 3'd6;
`else
   assign scale_layer = 1'b0;
   assign last_layer  = 3'd6;
`endif

   assign issue      = (state_q == S_ISSUE) && !hold_i;
   assign retire     = ret_q[DLY-1].vld;
   assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(retire);

   // len is a power of two, so group/offset split is a mask and the group base a shift
   assign shift   = inv_q ? layer_q + 3'd1 : 3'd7 - layer_q;
   assign bfly_x  = ADDR_W'(bfly_q);
   assign len_v   = ADDR_W'(1) << shift;
   assign mask_v  = len_v - ADDR_W'(1);
   assign grp_end = (bfly_x & mask_v) == mask_v;

   always_comb begin
      addr_a = ((bfly_x & ~mask_v) << 1) | (bfly_x & mask_v);
      addr_b = addr_a | len_v;
      mode   = inv_q ? PE_MODE_INTT : PE_MODE_NTT;
      if (scale_layer) begin
         addr_a = {bfly_x[ADDR_W-2:0], 1'b0};
         addr_b = {bfly_x[ADDR_W-2:0], 1'b1};
         mode   = PE_MODE_MUL;
      end
   end

   always_comb begin
      state_d = state_q;
      layer_d = layer_q;
      bfly_d  = bfly_q;
      k_d     = k_q;
      inv_d   = inv_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_ISSUE;
               inv_d   = inv_i;
               layer_d = 3'd0;
               bfly_d  = 7'd0;
               k_d     = inv_i ? 7'd127 : 7'd1;
            end
         end
         S_ISSUE: begin
            if (issue) begin
               bfly_d = bfly_q + 7'd1;
               if (grp_end && !scale_layer) k_d = inv_q ? k_q - 7'd1 : k_q + 7'd1;
               if (bfly_q == 7'd127) state_d = S_DRAIN;
            end
         end
         // wait until every write of this layer has landed before reading the next
         S_DRAIN: begin
            if (inflight_d == '0) begin
               if (layer_q == last_layer) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ISSUE;
                  layer_d = layer_q + 3'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         layer_q    <= '0;
         bfly_q     <= '0;
         k_q        <= '0;
         inv_q      <= 1'b0;
         err_q      <= 1'b0;
         inflight_q <= '0;
         for (int i = 0; i < DLY; i++) ret_q[i] <= '0;
         for (int i = 0; i < MEM_LAT; i++) iss_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         layer_q    <= layer_d;
         bfly_q     <= bfly_d;
         k_q        <= k_d;
         inv_q      <= inv_d;
         inflight_q <= inflight_d;
         ret_q[0]   <= '{vld: issue, a: rd_addr_a_o, b: rd_addr_b_o};
         for (int i = 1; i < DLY; i++) ret_q[i] <= ret_q[i-1];
         iss_q[0]   <= '{vld: issue, tw: k_q, mode: mode, scale: issue && scale_layer};
         for (int i = 1; i < MEM_LAT; i++) iss_q[i] <= iss_q[i-1];
         if (pe_valid_i != retire) err_q <= 1'b1;
      end
   end

   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign err_o       = err_q;
   assign rd_en_o     = issue;
   assign rd_addr_a_o = issue ? addr_a : '0;
   assign rd_addr_b_o = issue ? addr_b : '0;
   assign tw_idx_o    = iss_q[MEM_LAT-1].tw;
   assign pe_ctrl_o   = iss_q[MEM_LAT-1].mode;
   assign pe_valid_o  = iss_q[MEM_LAT-1].vld;
   assign scale_o     = iss_q[MEM_LAT-1].scale;
   assign wr_en_o     = pe_valid_i;
   assign wr_addr_a_o = ret_q[DLY-1].a;
   assign wr_addr_b_o = ret_q[DLY-1].b;
endmodule

// File: tb/tb_ntt_sched.sv
// Bench for ntt_sched: FIPS-loop reference sequences, directed vector table, random hold,
// start-while-busy, mid-pass reset and dropped-valid error cases.
module tb_ntt_sched;
   import ntt_sched_pkg::*;
   localparam int MEM_LAT  = 1;
   localparam int PIPE_LAT = 4;
   localparam int AW       = 8;

   logic clk, rst_n, start_i, inv_i, hold_i;
   logic busy_o, done_o, err_o, rd_en_o, pe_valid_o, pe_valid_i, wr_en_o, scale_o;
   logic [AW-1:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
   logic [6:0] tw_idx_o;
   pe_mode_e pe_ctrl_o;

   ntt_sched #(.MEM_LAT(MEM_LAT), .PIPE_LAT(PIPE_LAT), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst_n), .start_i(start_i), .inv_i(inv_i), .hold_i(hold_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rd_en_o(rd_en_o),
      .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o), .tw_idx_o(tw_idx_o),
      .pe_ctrl_o(pe_ctrl_o), .pe_valid_o(pe_valid_o), .pe_valid_i(pe_valid_i),
      .wr_en_o(wr_en_o), .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o),
      .scale_o(scale_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // PE model: fixed pipeline, can drop one chosen valid
   logic [PIPE_LAT-1:0] pe_sr;
   int pe_cnt;
   int drop_at = -1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_sr  <= '0;
         pe_cnt <= 0;
      end else begin
         pe_sr <= {pe_sr[PIPE_LAT-2:0], pe_valid_o && (pe_cnt != drop_at)};
         if (pe_valid_o) pe_cnt <= pe_cnt + 1;
      end
   end
   assign pe_valid_i = pe_sr[PIPE_LAT-1];

   // reference op list straight from the FIPS 203 NTT/INTT loop nests
   int ref_a[$], ref_b[$], ref_tw[$], ref_md[$], ref_sc[$];
   function automatic void add_ref(int a, int b, int tw, int md, int sc);
      ref_a.push_back(a); ref_b.push_back(b); ref_tw.push_back(tw);
      ref_md.push_back(md); ref_sc.push_back(sc);
   endfunction
   function automatic void build_ref(input bit inv);
      int k;
      ref_a.delete(); ref_b.delete(); ref_tw.delete(); ref_md.delete(); ref_sc.delete();
      if (!inv) begin
         k = 1;
         for (int len = 128; len >= 2; len = len / 2)
            for (int st = 0; st < 256; st += 2 * len) begin
               for (int j = st; j < st + len; j++) add_ref(j, j + len, k, 0, 0);
               k++;
            end
      end else begin
         k = 127;
         for (int len = 2; len <= 128; len = len * 2)
            for (int st = 0; st < 256; st += 2 * len) begin
               for (int j = st; j < st + len; j++) add_ref(j, j + len, k, 1, 0);
               k--;
            end
`ifdef SCHED_FINAL_SCALE_EN
         for (int j = 0; j < 128; j++) add_ref(2 * j, 2 * j + 1, -1, 2, 1);
`endif
      end
   endfunction

   // monitor: observed issue/PE/write streams and cross-layer RAW hazard detection
   int mon_a[$], mon_b[$], mon_tw[$], mon_md[$], mon_sc[$], mon_wa[$], mon_wb[$];
   int hazards;
   bit pend [256];
   bit mon_clr = 1'b0;
   always @(negedge clk) begin
      if (mon_clr) begin
         mon_a.delete(); mon_b.delete(); mon_tw.delete(); mon_md.delete(); mon_sc.delete();
         mon_wa.delete(); mon_wb.delete();
         hazards = 0;
         for (int i = 0; i < 256; i++) pend[i] = 1'b0;
      end else if (rst_n) begin
         if (rd_en_o && (pend[rd_addr_a_o] || pend[rd_addr_b_o])) hazards++;
         if (wr_en_o) begin
            mon_wa.push_back(int'(wr_addr_a_o)); mon_wb.push_back(int'(wr_addr_b_o));
            pend[wr_addr_a_o] = 1'b0; pend[wr_addr_b_o] = 1'b0;
         end
         if (rd_en_o) begin
            mon_a.push_back(int'(rd_addr_a_o)); mon_b.push_back(int'(rd_addr_b_o));
            pend[rd_addr_a_o] = 1'b1; pend[rd_addr_b_o] = 1'b1;
         end
         if (pe_valid_o) begin
            mon_tw.push_back(int'(tw_idx_o)); mon_md.push_back(int'(pe_ctrl_o));
            mon_sc.push_back(int'(scale_o));
         end
      end
   end

   typedef struct {
      bit inv;
      int idx;
      int a;
      int b;
      int tw;
   } vec_t;
   vec_t vt [9];

   task automatic apply_table(input bit inv);
      for (int i = 0; i < 9; i++) begin
         if (vt[i].inv == inv) begin
            chk($sformatf("tbl%0d_a", i),  (vt[i].idx < mon_a.size())  ? mon_a[vt[i].idx]  : -1, vt[i].a);
            chk($sformatf("tbl%0d_b", i),  (vt[i].idx < mon_b.size())  ? mon_b[vt[i].idx]  : -1, vt[i].b);
            chk($sformatf("tbl%0d_tw", i), (vt[i].idx < mon_tw.size()) ? mon_tw[vt[i].idx] : -1, vt[i].tw);
         end
      end
   endtask

   // drives one pass; returns the cycle (start edge = cycle 0) where done_o was seen
   task automatic run_pass(input bit inv, input int hold_pct, input int pulse_cyc,
                           input int abort_cyc, output int done_cyc);
      mon_clr = 1'b1;
      @(posedge clk); #1;
      mon_clr = 1'b0;
      start_i = 1'b1; inv_i = inv; hold_i = 1'b0;
      @(posedge clk); #1;
      start_i = 1'b0;
      done_cyc = -1;
      for (int n = 1; n <= 6000; n++) begin
         hold_i  = ($urandom_range(99) < hold_pct);
         start_i = (n == pulse_cyc);
         inv_i   = (n == pulse_cyc) ? ~inv : inv;
         if (n == abort_cyc) begin
            rst_n = 1'b0;
            #1;
            chk("abort_rd_en", rd_en_o, 0);
            chk("abort_busy", busy_o, 0);
            chk("abort_pe_valid", pe_valid_o, 0);
            chk("abort_wr_en", wr_en_o, 0);
            chk("abort_rd_addr", rd_addr_a_o, 0);
            hold_i = 1'b0; start_i = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            done_cyc = -2;
            break;
         end
         @(negedge clk);
         if (done_o) begin
            done_cyc = n;
            break;
         end
         @(posedge clk); #1;
      end
      hold_i = 1'b0; start_i = 1'b0;
      if (done_cyc == -1) chk("pass_timeout", 0, 1);
   endtask

   task automatic check_pass(input string tag, input bit timed, input int done_cyc);
      int n_ops, m_rd, m_pe, m_wr;
      n_ops = ref_a.size();
      if (timed) chk({tag, "_done_cycle"}, done_cyc, n_ops + (n_ops / 128) * (MEM_LAT + PIPE_LAT) + 1);
      chk({tag, "_busy_in_done"}, busy_o, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_busy_after"}, busy_o, 0);
      chk({tag, "_done_after"}, done_o, 0);
      chk({tag, "_rd_count"}, mon_a.size(), n_ops);
      chk({tag, "_pe_count"}, mon_tw.size(), n_ops);
      chk({tag, "_wr_count"}, mon_wa.size(), n_ops);
      m_rd = 0; m_pe = 0; m_wr = 0;
      for (int i = 0; i < n_ops; i++) begin
         if (i >= mon_a.size() || mon_a[i] != ref_a[i] || mon_b[i] != ref_b[i]) m_rd++;
         if (i >= mon_tw.size() || (ref_tw[i] >= 0 && mon_tw[i] != ref_tw[i]) ||
             mon_md[i] != ref_md[i] || mon_sc[i] != ref_sc[i]) m_pe++;
         if (i >= mon_wa.size() || mon_wa[i] != ref_a[i] || mon_wb[i] != ref_b[i]) m_wr++;
      end
      chk({tag, "_rd_seq_mismatches"}, m_rd, 0);
      chk({tag, "_pe_seq_mismatches"}, m_pe, 0);
      chk({tag, "_wr_seq_mismatches"}, m_wr, 0);
      chk({tag, "_raw_hazards"}, hazards, 0);
      chk({tag, "_err"}, err_o, 0);
   endtask

   initial begin
      int dc;
      vt[0] = '{0, 0,   0,   128, 1};
      vt[1] = '{0, 128, 0,   64,  2};
      vt[2] = '{0, 192, 128, 192, 3};
      vt[3] = '{0, 895, 253, 255, 127};
      vt[4] = '{1, 0,   0,   2,   127};
      vt[5] = '{1, 1,   1,   3,   127};
      vt[6] = '{1, 2,   4,   6,   126};
      vt[7] = '{1, 768, 0,   128, 1};
      vt[8] = '{1, 895, 127, 255, 1};

      rst_n = 1'b0; start_i = 1'b0; inv_i = 1'b0; hold_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_rd_en", rd_en_o, 0);
      chk("rst_rd_a", rd_addr_a_o, 0);
      chk("rst_rd_b", rd_addr_b_o, 0);
      chk("rst_tw", tw_idx_o, 0);
      chk("rst_pe_ctrl", pe_ctrl_o, PE_MODE_NTT);
      chk("rst_pe_valid", pe_valid_o, 0);
      chk("rst_wr_en", wr_en_o, 0);
      chk("rst_scale", scale_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      build_ref(1'b0);
      run_pass(1'b0, 0, 0, 0, dc);
      check_pass("ntt", 1'b1, dc);
      apply_table(1'b0);

      build_ref(1'b1);
      run_pass(1'b1, 0, 0, 0, dc);
      check_pass("intt", 1'b1, dc);
      apply_table(1'b1);

      build_ref(1'b0);
      run_pass(1'b0, 50, 0, 0, dc);
      check_pass("ntt_hold", 1'b0, dc);

      build_ref(1'b1);
      run_pass(1'b1, 50, 0, 0, dc);
      check_pass("intt_hold", 1'b0, dc);

      build_ref(1'b0);
      run_pass(1'b0, 0, 300, 0, dc);
      check_pass("ntt_restart_ignored", 1'b1, dc);

      run_pass(1'b0, 0, 0, 450, dc);
      chk("abort_err", err_o, 0);
      run_pass(1'b0, 0, 0, 0, dc);
      check_pass("ntt_after_abort", 1'b1, dc);

      drop_at = pe_cnt + 37;
      run_pass(1'b0, 0, 0, 0, dc);
      chk("drop_err_set", err_o, 1);
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("drop_err_sticky", err_o, 1);
      drop_at = -1;
      rst_n = 1'b0;
      #1;
      chk("drop_err_reset", err_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
